// File: rtl/pulse_level_gen.sv
// pulse_level_gen
//   Turns a one-cycle start request into a clean, width-controlled level pulse.
//   The level stays high for max(high_len,1) cycles and then stays low for low_len guard cycles.
//   After that the block is ready again.
//   All outputs are registered and update on the acceptance edge, so no latency is added.
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_start      : request pulse
//   i_high_len   : high-phase length in cycles (0 treated as 1)
//   i_low_len    : low guard length in cycles (0 allowed)
//   o_level_out  : generated level
//   o_busy       : request in progress
//   o_done       : one-cycle pulse on request completion
//   o_drop       : one-cycle pulse when a start arrives while busy (ignored, not queued)
module pulse_level_gen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_high_len,
    input  logic [WIDTH-1:0] i_low_len,
    output logic             o_level_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_drop
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_low_len;
    logic             r_level;
    logic             r_busy;
    logic             r_done;
    logic             r_drop;

    // Initial count for the high phase; a zero length behaves as one cycle.
    logic [WIDTH-1:0] w_high_m1;
    assign w_high_m1 = (i_high_len == '0) ? '0 : i_high_len - 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_low_len <= '0;
            r_level   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_drop <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_cnt     <= w_high_m1;
                        r_low_len <= i_low_len;
                        r_state   <= StHigh;
                        r_level   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                StHigh: begin
                    if (i_start) begin
                        r_drop <= 1'b1;
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_low_len != '0) begin
                        r_cnt   <= r_low_len - 1'b1;
                        r_state <= StLow;
                        r_level <= 1'b0;
                    end else begin
                        r_state <= StIdle;
                        r_level <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                StLow: begin
                    if (i_start) begin
                        r_drop <= 1'b1;
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_level <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_level_out = r_level;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_drop      = r_drop;

endmodule

// File: tb/tb_pulse_level_gen.sv
// Directed bench for pulse_level_gen.
// Samples are taken 1 ns after each rising edge.
// A sample taken at index i shows the outputs after edge k+i, where k is the accepting edge.
module tb_pulse_level_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic       level_out;
    logic       busy;
    logic       done;
    logic       drop;

    int n_checks;
    int n_fail;

    pulse_level_gen #(
        .WIDTH(8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_high_len (high_len),
        .i_low_len  (low_len),
        .o_level_out(level_out),
        .o_busy     (busy),
        .o_done     (done),
        .o_drop     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one start with the given lengths; it is accepted at the next edge.
    task automatic go(input int h, input int l);
        high_len = 8'(h);
        low_len  = 8'(l);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Walk one request from its acceptance sample until busy falls.
    // Extra starts are injected so that they are seen at the edges k+d1 and k+d2.
    task automatic measure(input int d1, input int d2, input int limit,
                           output int hi, output int bsy, output int dn, output int drp,
                           output int tmo);
        hi = 0; bsy = 0; dn = 0; drp = 0; tmo = 1;
        for (int i = 0; i < limit; i++) begin
            if (level_out) hi++;
            if (busy) bsy++;
            if (done) dn++;
            if (drop) drp++;
            if (!busy) begin
                tmo = 0;
                break;
            end
            start = ((i + 1) == d1) || ((i + 1) == d2);
            tick();
        end
        start = 1'b0;
    endtask

    int hi, bsy, dn, drp, tmo;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        high_len = 8'd3;
        low_len  = 8'd2;

        // Reset held for 3 cycles with start asserted.
        tick(); tick(); tick();
        chk("rst_level", int'(level_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_drop", int'(drop), 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", int'(busy), 0);

        // First request: H=3, L=2.
        go(3, 2);
        measure(-1, -1, 50, hi, bsy, dn, drp, tmo);
        chk("r1_tmo", tmo, 0);
        chk("r1_high", hi, 3);
        chk("r1_busy", bsy, 5);
        chk("r1_done", dn, 1);
        tick();
        chk("r1_done_clr", int'(done), 0);

        // high_len=0, low_len=0.
        go(0, 0);
        measure(-1, -1, 50, hi, bsy, dn, drp, tmo);
        chk("z0_tmo", tmo, 0);
        chk("z0_high", hi, 1);
        chk("z0_busy", bsy, 1);
        chk("z0_done", dn, 1);
        chk("z0_level_at_done", int'(level_out), 0);
        tick();

        // high_len=0, low_len=4.
        go(0, 4);
        measure(-1, -1, 50, hi, bsy, dn, drp, tmo);
        chk("z4_tmo", tmo, 0);
        chk("z4_high", hi, 1);
        chk("z4_busy", bsy, 5);
        chk("z4_done", dn, 1);
        tick();

        // Starts at cycles 2 (high phase) and 7 (low phase) are dropped.
        go(5, 5);
        measure(2, 7, 50, hi, bsy, dn, drp, tmo);
        chk("dr_tmo", tmo, 0);
        chk("dr_high", hi, 5);
        chk("dr_busy", bsy, 10);
        chk("dr_done", dn, 1);
        chk("dr_drop", drp, 2);
        tick();

        // Back-to-back: H=2, L=0; start raised in every done cycle.
        go(2, 0);
        for (int i = 0; i < 9; i++) begin
            chk("b2b_level", int'(level_out), ((i % 3) != 2) ? 1 : 0);
            chk("b2b_done", int'(done), ((i % 3) == 2) ? 1 : 0);
            chk("b2b_drop", int'(drop), 0);
            start = ((i % 3) == 2);
            tick();
        end
        start = 1'b0;
        tick(); tick(); tick();

        // Maximum lengths.
        go(255, 255);
        measure(-1, -1, 1000, hi, bsy, dn, drp, tmo);
        chk("max_tmo", tmo, 0);
        chk("max_high", hi, 255);
        chk("max_busy", bsy, 510);
        chk("max_done", dn, 1);
        tick();

        // Repeat run aborted by an asynchronous reset at cycle 100.
        go(255, 255);
        for (int i = 0; i < 100; i++) tick();
        chk("ab_pre_level", int'(level_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_level", int'(level_out), 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_done", int'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ab_post_done", int'(done), 0);
        chk("ab_post_busy", int'(busy), 0);

        // A fresh request after the abort completes normally.
        go(3, 2);
        measure(-1, -1, 50, hi, bsy, dn, drp, tmo);
        chk("fr_tmo", tmo, 0);
        chk("fr_high", hi, 3);
        chk("fr_busy", bsy, 5);
        chk("fr_done", dn, 1);
        tick();

        // Length input change mid-request has no effect.
        high_len = 8'd4;
        low_len  = 8'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        high_len = 8'd1;
        measure(-1, -1, 50, hi, bsy, dn, drp, tmo);
        chk("mc_tmo", tmo, 0);
        chk("mc_high", hi, 4);
        chk("mc_busy", bsy, 4);
        chk("mc_done", dn, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
